// File: rtl/div_responder_pkg.sv
// Shared divider definitions: ALU op codes, iteration count and FSM state encodings.
package div_responder_pkg;

    localparam int unsigned DIV_CYCLES = 32;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_responder.sv
// Multi-cycle restoring divider for the ALU: signed/unsigned, {remainder, quotient} result,
// start/ready handshake with pipeline annul and divide-by-zero reporting.
module div_responder
    import div_responder_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t        state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  quot;
    logic [WIDTH-1:0]  divisor;
    logic [WIDTH-1:0]  rem;
    logic              neg_q;
    logic              neg_r;
    logic              zero_div;

    logic [WIDTH-1:0]  mag1;
    logic [WIDTH-1:0]  mag2;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  q_final;
    logic [WIDTH-1:0]  r_final;

    always_comb begin
        mag1      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        mag2      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        rem_shift = {rem, quot[WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor};
        q_final   = neg_q ? -quot : quot;
        r_final   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            quot     <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
        end else if (annul) begin
            state    <= ST_IDLE;
            result   <= '0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result   <= '0;
                    ready    <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        quot     <= mag1;
                        divisor  <= mag2;
                        rem      <= '0;
                        cnt      <= '0;
                        neg_q    <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_r    <= signed_div && opdata1[WIDTH-1];
                        zero_div <= 1'b0;
                        state    <= (opdata2 == '0) ? ST_BYZERO : ST_ON;
                    end
                end
                ST_BYZERO: begin
                    quot     <= '0;
                    rem      <= '0;
                    neg_q    <= 1'b0;
                    neg_r    <= 1'b0;
                    zero_div <= 1'b1;
                    state    <= ST_END;
                end
                ST_ON: begin
                    // quot doubles as the dividend shift register; quotient bits enter at the LSB
                    if (!diff[WIDTH]) begin
                        rem  <= diff[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_END;
                    end
                end
                ST_END: begin
                    if (!start) begin
                        state    <= ST_IDLE;
                        result   <= '0;
                        ready    <= 1'b0;
                        div_zero <= 1'b0;
                    end else begin
                        result   <= {r_final, q_final};
                        ready    <= 1'b1;
                        div_zero <= zero_div;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
